dfg_sched_eval: RTL and testbench

- Parametrised, handshaked successor to the team's fixed 8-bit DFG datapath.
- Evaluates a fixed data-flow graph over five operands using one shared adder and one shared multiplier, sequenced by an FSM controller.
- Adds a valid/ready handshake, a width parameter, optional saturating arithmetic and a completed-result counter.
- Sits between an operand producer and a result consumer; one evaluation is in flight at a time.

---
 rtl/dfg_sched_eval.sv | 140 ++++++++++++++
 tb/tb_dfg_sched_eval.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dfg_sched_eval.sv
// Evaluates x = (a+c)*(b+d) + b and y = (a+c)*(b+d) * e on one shared adder and one shared
// multiplier, sequenced by a six-state controller with valid/ready handshakes on both sides.
module dfg_sched_eval #(
   parameter int W     = 8,
   parameter int SAT   = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     c,
   input  logic [W-1:0]     d,
   input  logic [W-1:0]     e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     x,
   output logic [W-1:0]     y,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADD1 = 3'd1,
      ADD2 = 3'd2,
      MUL  = 3'd3,
      FIN  = 3'd4,
      OUT  = 3'd5
   } state_t;

   state_t state;

   logic [W-1:0] ra, rb, rc, rd, re;
   logic [W-1:0] rt1, rt2, rt3;
   logic [W-1:0] add_a, add_b, mul_a, mul_b;
   logic [W-1:0] add_res, mul_res;

   // Each operation clamps on its own full-precision result, so saturation propagates through the graph.
   function automatic logic [W-1:0] sat_add(input logic [W-1:0] p, input logic [W-1:0] q);
      logic [W:0] s;
      s = {1'b0, p} + {1'b0, q};
      if (SAT != 0 && s[W])
         return '1;
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] sat_mul(input logic [W-1:0] p, input logic [W-1:0] q);
      logic [2*W-1:0] m;
      m = {{W{1'b0}}, p} * {{W{1'b0}}, q};
      if (SAT != 0 && (|m[2*W-1:W]))
         return '1;
      return m[W-1:0];
   endfunction

   always_comb begin
      add_a = ra;
      add_b = rc;
      mul_a = rt1;
      mul_b = rt2;
      case (state)
         ADD2: begin
            add_a = rb;
            add_b = rd;
         end
         FIN: begin
            add_a = rt3;
            add_b = rb;
            mul_a = rt3;
            mul_b = re;
         end
         default: ;
      endcase
   end

   assign add_res = sat_add(add_a, add_b);
   assign mul_res = sat_mul(mul_a, mul_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         rc       <= '0;
         rd       <= '0;
         re       <= '0;
         rt1      <= '0;
         rt2      <= '0;
         rt3      <= '0;
         x        <= '0;
         y        <= '0;
         done_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ra    <= a;
                  rb    <= b;
                  rc    <= c;
                  rd    <= d;
                  re    <= e;
                  state <= ADD1;
               end
            end
            ADD1: begin
               rt1   <= add_res;
               state <= ADD2;
            end
            ADD2: begin
               rt2   <= add_res;
               state <= MUL;
            end
            MUL: begin
               rt3   <= mul_res;
               state <= FIN;
            end
            FIN: begin
               x     <= add_res;
               y     <= mul_res;
               state <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  done_cnt <= done_cnt + CNT_W'(1);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake flags depend on the state register alone; unused encodings read as not busy.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign busy      = (state inside {ADD1, ADD2, MUL, FIN, OUT});

endmodule

// File: tb/tb_dfg_sched_eval.sv
// Bench for dfg_sched_eval: three instances (wrapping, saturating, 2-bit counter) run in lockstep
// on shared stimulus and are checked against an arithmetic reference of the graph.
module tb_dfg_sched_eval;
   localparam int W    = 8;
   localparam int MAXV = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [W-1:0] a = '0, b = '0, c = '0, d = '0, e = '0;

   logic in_ready0, out_valid0, busy0;
   logic in_ready1, out_valid1, busy1;
   logic in_ready2, out_valid2, busy2;
   logic [W-1:0] x0, y0, x1, y1, x2, y2;
   logic [15:0] done_cnt0, done_cnt1;
   logic [1:0]  done_cnt2;

   dfg_sched_eval #(.W(W), .SAT(0), .CNT_W(16)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .out_valid(out_valid0), .out_ready(out_ready), .x(x0), .y(y0),
      .busy(busy0), .done_cnt(done_cnt0)
   );

   dfg_sched_eval #(.W(W), .SAT(1), .CNT_W(16)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .out_valid(out_valid1), .out_ready(out_ready), .x(x1), .y(y1),
      .busy(busy1), .done_cnt(done_cnt1)
   );

   dfg_sched_eval #(.W(W), .SAT(0), .CNT_W(2)) dut_cnt2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .out_valid(out_valid2), .out_ready(out_ready), .x(x2), .y(y2),
      .busy(busy2), .done_cnt(done_cnt2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;
   int last_acc = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_op(input int v, input bit sat);
      if (v > MAXV)
         return sat ? MAXV : (v % (MAXV + 1));
      return v;
   endfunction

   function automatic void ref_graph(input int av, input int bv, input int cv, input int dv,
                                     input int ev, input bit sat, output int xo, output int yo);
      int t1, t2, t3;
      t1 = ref_op(av + cv, sat);
      t2 = ref_op(bv + dv, sat);
      t3 = ref_op(t1 * t2, sat);
      xo = ref_op(t3 + bv, sat);
      yo = ref_op(t3 * ev, sat);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_ops();
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom); e = W'($urandom);
   endtask

   // One full transaction from IDLE; hold>0 keeps out_ready low that many cycles in OUT.
   task automatic do_eval(input int av, input int bv, input int cv, input int dv, input int ev,
                          input int hold, input bit chk_ii);
      int ex0, ey0, ex1, ey1;
      logic [W-1:0] hx, hy;
      ref_graph(av, bv, cv, dv, ev, 1'b0, ex0, ey0);
      ref_graph(av, bv, cv, dv, ev, 1'b1, ex1, ey1);
      check_val("in_ready_idle", in_ready0, 1);
      a = W'(av); b = W'(bv); c = W'(cv); d = W'(dv); e = W'(ev);
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      tick();
      if (chk_ii) check_val("accept_spacing", cyc - last_acc, 6);
      last_acc = cyc;
      in_valid = 1'b0;
      scramble_ops();
      check_val("in_ready_after_accept", in_ready0, 0);
      check_val("busy_after_accept", busy0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("out_valid_early", out_valid0, 0);
         scramble_ops();
      end
      tick();
      check_val("out_valid_latency", out_valid0, 1);
      check_val("x_wrap", x0, ex0);
      check_val("y_wrap", y0, ey0);
      check_val("x_sat", x1, ex1);
      check_val("y_sat", y1, ey1);
      hx = x0;
      hy = y0;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         scramble_ops();
         tick();
         check_val("bp_out_valid", out_valid0, 1);
         check_val("bp_in_ready", in_ready0, 0);
         check_val("bp_x_stable", x0, hx);
         check_val("bp_y_stable", y0, hy);
         check_val("bp_cnt_stable", done_cnt0, 32'(exp_cnt % 65536));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_cnt++;
      check_val("done_cnt", done_cnt0, 32'(exp_cnt % 65536));
      check_val("done_cnt_w2", done_cnt2, 32'(exp_cnt % 4));
      check_val("out_valid_after_handoff", out_valid0, 0);
      check_val("busy_after_handoff", busy0, 0);
      check_val("x_held_after_handoff", x0, hx);
      check_val("y_held_after_handoff", y0, hy);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check_val("rst_in_ready", in_ready0, 1);
      check_val("rst_out_valid", out_valid0, 0);
      check_val("rst_busy", busy0, 0);
      check_val("rst_x", x0, 0);
      check_val("rst_y", y0, 0);
      check_val("rst_done_cnt", done_cnt0, 0);

      do_eval(1, 2, 3, 4, 5, 0, 1'b0);
      do_eval(200, 1, 100, 1, 3, 0, 1'b1);
      do_eval($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
              $urandom_range(0, MAXV), $urandom_range(0, MAXV), 10, 1'b0);

      // Abort an evaluation while it sits in MUL.
      a = 8'd9; b = 8'd8; c = 8'd7; d = 8'd6; e = 8'd5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check_val("busy_in_mul", busy0, 1);
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      exp_cnt = 0;
      check_val("midrst_in_ready", in_ready0, 1);
      check_val("midrst_busy", busy0, 0);
      check_val("midrst_out_valid", out_valid0, 0);
      check_val("midrst_x", x0, 0);
      check_val("midrst_y", y0, 0);
      check_val("midrst_done_cnt", done_cnt0, 0);
      check_val("midrst_done_cnt_w2", done_cnt2, 0);

      do_eval(1, 2, 3, 4, 5, 0, 1'b0);
      for (int k = 0; k < 4; k++)
         do_eval($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
                 $urandom_range(0, MAXV), $urandom_range(0, MAXV), 0, 1'b1);

      for (int k = 0; k < 30; k++)
         do_eval($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
                 $urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, 3), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
